// File: rtl/bitop_16_arbiter_pkg.sv
// Shared opcode and FSM state encodings for the two-requester bitwise-op arbiter.
// Imported by the RTL and by the testbench.
package bitop_16_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/bitop_16.sv
// Combinational bitwise logic unit: AND, OR, XOR, or NOT of operand a.
// Operand b is ignored for NOT.
module bitop_16
    import bitop_16_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/bitop_16_arbiter.sv
// Two-requester arbiter sharing one bitop_16 unit, one transaction at a time.
// The FSM walks IDLE -> EXEC -> RESP; a round-robin pointer breaks ties.
module bitop_16_arbiter
    import bitop_16_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [1:0]       req_op_0,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    output logic             rsp_valid_0,
    input  logic             rsp_ready_0,

    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [1:0]       req_op_1,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_1,

    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic             prio;
    logic             owner;
    logic             grant_0;
    logic             grant_1;
    op_t              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] unit_y;

    bitop_16 #(.WIDTH(WIDTH)) u_unit (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (unit_y)
    );

    // Grants are gated by rst_n so req_ready stays low while reset is held,
    // even though the state register already reads IDLE.
    always_comb begin
        grant_0    = 1'b0;
        grant_1    = 1'b0;
        state_next = state;

        if (state == IDLE && rst_n) begin
            if (req_valid_0 && (!req_valid_1 || !prio))
                grant_0 = 1'b1;
            else if (req_valid_1)
                grant_1 = 1'b1;
        end

        case (state)
            IDLE:    if (grant_0 || grant_1) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (owner ? rsp_ready_1 : rsp_ready_0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req_ready_0 = grant_0;
    assign req_ready_1 = grant_1;
    assign rsp_valid_0 = (state == RESP) && !owner;
    assign rsp_valid_1 = (state == RESP) && owner;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            owner    <= 1'b0;
            op_q     <= OP_AND;
            a_q      <= '0;
            b_q      <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_next;
            if (grant_0 || grant_1) begin
                owner <= grant_1;
                op_q  <= grant_1 ? op_t'(req_op_1) : op_t'(req_op_0);
                a_q   <= grant_1 ? req_a_1 : req_a_0;
                b_q   <= grant_1 ? req_b_1 : req_b_0;
            end
            if (state == EXEC)
                rsp_data <= unit_y;
            // Hand priority to the other requester once a response is consumed.
            if (state == RESP && state_next == IDLE)
                prio <= ~owner;
        end
    end

endmodule
